// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RV32I-subset pipeline: opcodes, function codes,
// ALU operations, pipeline register layouts and immediate extraction helpers.
package riscv_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_e;

    // An all-zero pipeline register is a bubble: every control bit is inactive.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        use_imm;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        is_br;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        reg_we;
    } mem_wb_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/riscv_pipeline_top_alu.sv
// Combinational ALU: two's-complement add/sub with wrap, bitwise ops, signed set-less-than.
module riscv_alu
    import riscv_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/riscv_pipeline_top.sv
// 5-stage pipelined RV32I-subset core with on-chip instruction/data memories.
// No forwarding or interlocks; beq resolves in EX and flushes the two younger slots.
module riscv_pipeline_top
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data
);

    localparam int          IAW     = $clog2(IMEM_WORDS);
    localparam int          DAW     = $clog2(DMEM_WORDS);
    localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

    logic [31:0] imem_q [IMEM_WORDS];
    logic [31:0] dmem_q [DMEM_WORDS];
    logic [31:0] regs_q [32];

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    id_ex_t      id_ex_q, id_ex_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [31:0] fetch_instr;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_val, rs2_val;
    id_ex_t      dec;
    logic [31:0] alu_b, alu_res;
    logic        alu_zero;
    logic        br_taken;
    logic [31:0] br_target;
    logic [DAW-1:0] dmem_idx;
    logic [31:0] load_data;

    // Program load port: writes every edge, out-of-range (or unknown) addresses fall through.
    always_ff @(posedge clk) begin
        if (write_address < 32'(IMEM_WORDS)) begin
            imem_q[write_address[IAW-1:0]] <= write_data;
        end
    end

    // IF
    assign fetch_instr = imem_q[pc_q[IAW+1:2]];

    always_comb begin
        pc_d    = br_taken ? br_target : ((pc_q + 32'd4) & PC_MASK);
        if_id_d = br_taken ? '0 : {pc_q, fetch_instr};
    end

    // ID: register read sees a same-cycle writeback.
    assign instr  = if_id_q.instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    always_comb begin
        rs1_val = regs_q[rs1];
        rs2_val = regs_q[rs2];
        if (mem_wb_q.reg_we && mem_wb_q.rd == rs1) rs1_val = mem_wb_q.wdata;
        if (mem_wb_q.reg_we && mem_wb_q.rd == rs2) rs2_val = mem_wb_q.wdata;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    always_comb begin
        dec         = '0;
        dec.pc      = if_id_q.pc;
        dec.rs1_val = rs1_val;
        dec.rs2_val = rs2_val;
        dec.rd      = instr[11:7];
        case (opcode)
            OP_R: begin
                dec.reg_we = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD_SUB}: dec.alu_op = ALU_ADD;
                    {F7_SUB,  F3_ADD_SUB}: dec.alu_op = ALU_SUB;
                    {F7_BASE, F3_AND}:     dec.alu_op = ALU_AND;
                    {F7_BASE, F3_OR}:      dec.alu_op = ALU_OR;
                    {F7_BASE, F3_XOR}:     dec.alu_op = ALU_XOR;
                    {F7_BASE, F3_SLT}:     dec.alu_op = ALU_SLT;
                    default:               dec.reg_we = 1'b0;
                endcase
            end
            OP_I: begin
                if (funct3 == F3_ADD_SUB) begin
                    dec.reg_we  = 1'b1;
                    dec.use_imm = 1'b1;
                    dec.imm     = imm_i(instr);
                end
            end
            OP_LW: begin
                if (funct3 == F3_WORD) begin
                    dec.reg_we  = 1'b1;
                    dec.mem_re  = 1'b1;
                    dec.use_imm = 1'b1;
                    dec.imm     = imm_i(instr);
                end
            end
            OP_SW: begin
                if (funct3 == F3_WORD) begin
                    dec.mem_we  = 1'b1;
                    dec.use_imm = 1'b1;
                    dec.imm     = imm_s(instr);
                end
            end
            OP_BR: begin
                if (funct3 == F3_BEQ) begin
                    dec.is_br  = 1'b1;
                    dec.alu_op = ALU_SUB;
                    dec.imm    = imm_b(instr);
                end
            end
            default: ;
        endcase
        id_ex_d = br_taken ? '0 : dec;
    end

    // EX
    assign alu_b = id_ex_q.use_imm ? id_ex_q.imm : id_ex_q.rs2_val;

    riscv_alu u_alu (
        .op     (id_ex_q.alu_op),
        .a      (id_ex_q.rs1_val),
        .b      (alu_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        br_taken          = id_ex_q.is_br && alu_zero;
        br_target         = (id_ex_q.pc + id_ex_q.imm) & PC_MASK;
        ex_mem_d          = '0;
        ex_mem_d.alu_res  = alu_res;
        ex_mem_d.rs2_val  = id_ex_q.rs2_val;
        ex_mem_d.rd       = id_ex_q.rd;
        ex_mem_d.reg_we   = id_ex_q.reg_we;
        ex_mem_d.mem_re   = id_ex_q.mem_re;
        ex_mem_d.mem_we   = id_ex_q.mem_we;
    end

    // MEM
    assign dmem_idx  = ex_mem_q.alu_res[DAW+1:2];
    assign load_data = dmem_q[dmem_idx];

    always_ff @(posedge clk) begin
        if (ex_mem_q.mem_we) begin
            dmem_q[dmem_idx] <= ex_mem_q.rs2_val;
        end
    end

    always_comb begin
        mem_wb_d        = '0;
        mem_wb_d.wdata  = ex_mem_q.mem_re ? load_data : ex_mem_q.alu_res;
        mem_wb_d.rd     = ex_mem_q.rd;
        mem_wb_d.reg_we = ex_mem_q.reg_we;
    end

    // WB and pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (mem_wb_q.reg_we && mem_wb_q.rd != 5'd0) begin
            regs_q[mem_wb_q.rd] <= mem_wb_q.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

endmodule

// File: tb/tb_riscv_pipeline_top.sv
// Bench for riscv_pipeline_top: loads a program while running, scoreboards every
// writeback, then peeks final register/memory state and exercises a mid-run reset.
module tb_riscv_pipeline_top;

    logic        clk;
    logic        reset;
    logic [31:0] write_address;
    logic [31:0] write_data;

    int n_cmp;
    int n_err;
    logic        mon_en;
    logic [36:0] exp_q[$];
    logic [36:0] wb_exp;

    riscv_pipeline_top dut (
        .clk           (clk),
        .reset         (reset),
        .write_address (write_address),
        .write_data    (write_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    // Driver tasks
    task automatic load_word(input int idx, input logic [31:0] data);
        write_address = 32'(idx);
        write_data    = data;
        @(negedge clk);
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] val);
        exp_q.push_back({rd, val});
    endtask

    // Scoreboard: each architectural writeback must match the next expected one.
    always @(negedge clk) begin
        if (mon_en && dut.mem_wb_q.reg_we && dut.mem_wb_q.rd != 5'd0) begin
            check_eq("wb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                wb_exp = exp_q.pop_front();
                check_eq($sformatf("wb_x%0d", wb_exp[36:32]),
                         64'({dut.mem_wb_q.rd, dut.mem_wb_q.wdata}), 64'(wb_exp));
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        mon_en = 1'b0;
        reset = 1'b1;
        write_address = '0;
        write_data = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_pc", 64'(dut.pc_q), 64'd0);
        check_eq("rst_x1", 64'(dut.regs_q[1]), 64'd0);
        check_eq("rst_wb_we", 64'(dut.mem_wb_q.reg_we), 64'd0);

        // Two full passes of the program loop are expected to write back identically.
        for (int p = 0; p < 2; p++) begin
            push_wb(5'd4,  32'd5);
            push_wb(5'd5,  32'd8);
            push_wb(5'd7,  32'd13);
            push_wb(5'd8,  32'd2);
            push_wb(5'd10, 32'd11);
            push_wb(5'd11, 32'd8);
            push_wb(5'd12, 32'd15);
            push_wb(5'd13, 32'd8);
            push_wb(5'd14, 32'd1);
            push_wb(5'd17, 32'd0);
            push_wb(5'd18, 32'hFFFF_FFFD);
            push_wb(5'd15, 32'd11);
            push_wb(5'd16, 32'd13);
            push_wb(5'd19, 32'd1);
            push_wb(5'd22, 32'hFFFF_FFFB);
            push_wb(5'd30, 32'd24);
        end

        mon_en = 1'b1;
        reset = 1'b0;
        load_word(3,  enc_addi(5'd0, 5'd0, 12'd7));
        load_word(10, enc_addi(5'd4, 5'd0, 12'd5));
        load_word(11, enc_addi(5'd5, 5'd0, 12'd8));
        load_word(15, enc_r(7'b0000000, 5'd4, 5'd5, 3'b000, 5'd7));
        load_word(16, enc_addi(5'd8, 5'd0, 12'd2));
        load_word(20, enc_r(7'b0100000, 5'd8, 5'd7, 3'b000, 5'd10));
        load_word(21, enc_r(7'b0000000, 5'd5, 5'd7, 3'b111, 5'd11));
        load_word(22, enc_r(7'b0000000, 5'd8, 5'd7, 3'b110, 5'd12));
        load_word(23, enc_r(7'b0000000, 5'd4, 5'd7, 3'b100, 5'd13));
        load_word(24, enc_sw(5'd10, 5'd0, 12'd4));
        load_word(25, enc_sw(5'd7, 5'd0, 12'd0));
        load_word(26, enc_r(7'b0000000, 5'd7, 5'd8, 3'b010, 5'd14));
        load_word(27, enc_r(7'b0000000, 5'd8, 5'd7, 3'b010, 5'd17));
        load_word(28, enc_addi(5'd18, 5'd0, 12'hFFD));
        load_word(29, enc_lw(5'd15, 5'd0, 12'd4));
        load_word(30, enc_lw(5'd16, 5'd0, 12'd0));
        load_word(32, enc_r(7'b0000000, 5'd4, 5'd18, 3'b010, 5'd19));
        load_word(33, enc_r(7'b0100000, 5'd4, 5'd0, 3'b000, 5'd22));
        load_word(34, enc_r(7'b0000000, 5'd16, 5'd15, 3'b000, 5'd30));
        load_word(35, 32'hF642_0AE3);
        load_word(36, enc_addi(5'd20, 5'd0, 12'd99));
        load_word(37, enc_addi(5'd21, 5'd0, 12'd77));
        write_address = '0;
        write_data = '0;

        repeat (60) @(negedge clk);
        mon_en = 1'b0;
        check_eq("wb_drained", 64'(exp_q.size()), 64'd0);

        check_eq("x0",  64'(dut.regs_q[0]),  64'd0);
        check_eq("x4",  64'(dut.regs_q[4]),  64'd5);
        check_eq("x5",  64'(dut.regs_q[5]),  64'd8);
        check_eq("x7",  64'(dut.regs_q[7]),  64'd13);
        check_eq("x8",  64'(dut.regs_q[8]),  64'd2);
        check_eq("x10", 64'(dut.regs_q[10]), 64'd11);
        check_eq("x15", 64'(dut.regs_q[15]), 64'd11);
        check_eq("x16", 64'(dut.regs_q[16]), 64'd13);
        check_eq("x19", 64'(dut.regs_q[19]), 64'd1);
        check_eq("x22", 64'(dut.regs_q[22]), 64'hFFFF_FFFB);
        check_eq("x30", 64'(dut.regs_q[30]), 64'd24);
        check_eq("x20_flushed", 64'(dut.regs_q[20]), 64'd0);
        check_eq("x21_flushed", 64'(dut.regs_q[21]), 64'd0);
        check_eq("dmem0", 64'(dut.dmem_q[0]), 64'd13);
        check_eq("dmem1", 64'(dut.dmem_q[1]), 64'd11);

        // Reset asserted mid-clock takes effect without waiting for an edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_pc", 64'(dut.pc_q), 64'd0);
        for (int r = 0; r < 32; r++) begin
            check_eq($sformatf("mid_rst_x%0d", r), 64'(dut.regs_q[r]), 64'd0);
        end
        check_eq("mid_rst_wb_we", 64'(dut.mem_wb_q.reg_we), 64'd0);
        check_eq("mid_rst_mem_we", 64'(dut.ex_mem_q.mem_we), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_hold_pc", 64'(dut.pc_q), 64'd0);
        check_eq("rst_hold_x30", 64'(dut.regs_q[30]), 64'd0);
        check_eq("rst_hold_dmem0", 64'(dut.dmem_q[0]), 64'd13);

        reset = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("rerun_x4",  64'(dut.regs_q[4]),  64'd5);
        check_eq("rerun_x10", 64'(dut.regs_q[10]), 64'd11);
        check_eq("rerun_x22", 64'(dut.regs_q[22]), 64'hFFFF_FFFB);
        check_eq("rerun_x30", 64'(dut.regs_q[30]), 64'd24);
        check_eq("rerun_x20", 64'(dut.regs_q[20]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
